// File: rtl/multiplier_arbiter.sv
// Round-robin arbiter sharing one iterative multiplier among N_REQ requesters.
// Define MUL_ARB_TIMEOUT_EN to add a WAIT watchdog that returns resp_err.
module multiplier_arbiter #(
    parameter int N_REQ          = 4,
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       resp_valid,
    input  logic [N_REQ-1:0]       resp_ready,
    output logic [2*WIDTH-1:0]     resp_r,
    output logic                   resp_err,
    output logic                   mul_valid_in,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    input  logic                   mul_valid_out,
    input  logic [2*WIDTH-1:0]     mul_r
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("multiplier_arbiter: illegal parameter set");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    gnt;
    logic [PW-1:0]    pick;
    logic             found;
    logic [N_REQ-1:0] gnt_onehot;
    logic [WIDTH-1:0] pick_a;
    logic [WIDTH-1:0] pick_b;
    logic             gnt_done;

    // Rotating priority search starting at ptr, wrapping modulo N_REQ.
    always_comb begin
        int            idx;
        logic [PW-1:0] sel;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            sel = PW'(idx);
            if (!found && req_valid[sel]) begin
                found = 1'b1;
                pick  = sel;
            end
        end
    end

    assign pick_a     = req_a[pick*WIDTH +: WIDTH];
    assign pick_b     = req_b[pick*WIDTH +: WIDTH];
    assign gnt_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << gnt;
    assign gnt_done   = resp_ready[gnt];

    // rst_n gating keeps req_ready low while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && found) begin
            req_ready[pick] = 1'b1;
        end
    end

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            gnt          <= '0;
            mul_valid_in <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
            resp_valid   <= '0;
            resp_r       <= '0;
            resp_err     <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            mul_valid_in <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        gnt          <= pick;
                        mul_a        <= pick_a;
                        mul_b        <= pick_b;
                        mul_valid_in <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (mul_valid_out) begin
                        resp_r     <= mul_r;
                        resp_err   <= 1'b0;
                        resp_valid <= gnt_onehot;
                        state      <= RESP;
                    end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        resp_r     <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= gnt_onehot;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (gnt_done) begin
                        resp_valid <= '0;
                        resp_err   <= 1'b0;
                        ptr        <= (gnt == PW'(N_REQ - 1)) ? '0 : gnt + PW'(1);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign resp_err = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            gnt          <= '0;
            mul_valid_in <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
            resp_valid   <= '0;
            resp_r       <= '0;
        end else begin
            mul_valid_in <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        gnt          <= pick;
                        mul_a        <= pick_a;
                        mul_b        <= pick_b;
                        mul_valid_in <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (mul_valid_out) begin
                        resp_r     <= mul_r;
                        resp_valid <= gnt_onehot;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (gnt_done) begin
                        resp_valid <= '0;
                        ptr        <= (gnt == PW'(N_REQ - 1)) ? '0 : gnt + PW'(1);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Bench for multiplier_arbiter: directed and random requests against a
// queue-free round-robin reference and a behavioural multiplier with set latency.
module tb_multiplier_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TC = 128;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   resp_valid;
    logic [N-1:0]   resp_ready = '0;
    logic [2*W-1:0] resp_r;
    logic           resp_err;
    logic           mul_valid_in;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic           mul_valid_out = 1'b0;
    logic [2*W-1:0] mul_r = '0;

    logic [W-1:0] A [N];
    logic [W-1:0] B [N];

    int checks = 0;
    int failures = 0;
    int ptr_m = 0;

    int             mul_lat = 1;
    bit             withhold = 1'b0;
    int             mcnt = 0;
    logic [2*W-1:0] mprod = '0;

    multiplier_arbiter #(
        .N_REQ(N),
        .WIDTH(W),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_r(resp_r),
        .resp_err(resp_err),
        .mul_valid_in(mul_valid_in),
        .mul_a(mul_a),
        .mul_b(mul_b),
        .mul_valid_out(mul_valid_out),
        .mul_r(mul_r)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = A[i];
            req_b[i*W +: W] = B[i];
        end
    end

    // Behavioural multiplier: result level rises mul_lat cycles after start.
    always @(posedge clk) begin
        if (mul_valid_in) begin
            mcnt          <= mul_lat;
            mprod         <= {32'b0, mul_a} * {32'b0, mul_b};
            mul_valid_out <= 1'b0;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1 && !withhold) begin
                mul_valid_out <= 1'b1;
                mul_r         <= mprod;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] one;
        one = 1;
        return (g < 0) ? '0 : (one << g);
    endfunction

    function automatic int winner();
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (ptr_m + k) % N;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic serve(input int stall, input int lat, input bit hold);
        int             g;
        int             n;
        logic [2*W-1:0] exp;
        mul_lat  = lat;
        withhold = hold;
        #1;
        n = 0;
        while (req_ready == '0 && n < 20) begin
            tick();
            n++;
        end
        g = winner();
        check("grant", req_ready, onehot(g));
        if (g < 0) return;
        exp = hold ? '0 : {32'b0, A[g]} * {32'b0, B[g]};
        tick();
        check("issue_pulse", mul_valid_in, 1'b1);
        check("mul_a", mul_a, A[g]);
        check("mul_b", mul_b, B[g]);
        tick();
        n = 1;
        while (resp_valid == '0 && n < 400) begin
            check("wait_quiet", {req_ready, mul_valid_in, mul_a, mul_b},
                  {{N{1'b0}}, 1'b0, A[g], B[g]});
            tick();
            n++;
        end
        check("latency", n, hold ? TC + 1 : lat + 2);
        check("resp_valid", resp_valid, onehot(g));
        check("resp_r", resp_r, exp);
        check("resp_err", resp_err, hold);
        for (int s = 0; s < stall; s++) begin
            resp_ready = N'($urandom) & ~onehot(g);
            req_valid  = req_valid | N'($urandom);
            tick();
            check("stall_hold", {resp_valid, resp_r, req_ready, mul_valid_in},
                  {onehot(g), exp, {N{1'b0}}, 1'b0});
        end
        resp_ready = N'($urandom) | onehot(g);
        tick();
        check("handshake", {resp_valid, resp_err}, '0);
        resp_ready = '0;
        ptr_m = (g + 1) % N;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            A[i] = '0;
            B[i] = '0;
        end
        req_valid = '1;
        tick();
        tick();
        check("reset_outs", {req_ready, resp_valid, resp_r, resp_err,
                             mul_valid_in, mul_a, mul_b}, '0);
        req_valid = '0;
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_no_req", {req_ready, mul_valid_in, resp_valid}, '0);

        // all four held: expect 0,1,2,3 then wrap to 0
        for (int i = 0; i < N; i++) begin
            A[i] = W'(i + 2);
            B[i] = 3;
        end
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            check("rr_order", winner(), k % N);
            serve(0, 2 + k, 1'b0);
        end

        req_valid = 4'b0001;
        A[0] = 7;
        B[0] = 6;
        serve(0, 3, 1'b0);
        check("prod_42", resp_r, 64'd42);

        A[2] = 32'hFFFF_FFFF;
        B[2] = 32'hFFFF_FFFF;
        req_valid = 4'b0100;
        serve(0, 1, 1'b0);
        check("prod_max", resp_r, 64'hFFFF_FFFE_0000_0001);

        A[1] = 32'd1234;
        B[1] = 32'd5678;
        req_valid = 4'b0010;
        serve(10, 4, 1'b0);

        for (int it = 0; it < 16; it++) begin
            for (int i = 0; i < N; i++) begin
                A[i] = $urandom;
                B[i] = $urandom;
            end
            req_valid = N'($urandom_range(1, 15));
            serve($urandom_range(0, 3), $urandom_range(1, 6), 1'b0);
        end

`ifdef MUL_ARB_TIMEOUT_EN
        req_valid = 4'b0001;
        A[0] = 9;
        B[0] = 9;
        serve(2, 1, 1'b1);
`endif

        // reset while WAIT, with the multiplier still counting
        req_valid = 4'b0100;
        A[2] = 11;
        B[2] = 13;
        mul_lat  = 20;
        withhold = 1'b0;
        #1;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("reset_mid_op", {req_ready, resp_valid, resp_r, resp_err,
                               mul_valid_in, mul_a, mul_b}, '0);
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        ptr_m = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (resp_valid != '0 || mul_valid_in) begin
                check("no_stale", {resp_valid, mul_valid_in}, '0);
            end
        end
        check("quiet_after_rst", {resp_valid, mul_valid_in, req_ready}, '0);
        req_valid = 4'b1000;
        A[3] = 5;
        B[3] = 5;
        serve(0, 3, 1'b0);
        check("prod_25", resp_r, 64'd25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
